// File: rtl/anc_pkg.sv
// Shared types and constants for the ANC frame sequencer slice.
package anc_pkg;

    localparam int ANC_DATA_W      = 16;
    localparam int ANC_TIMEOUT_CYC = 4000;

    typedef enum logic [1:0] {
        IDLE,
        FILT,
        UPD,
        OUT
    } anc_state_t;

    // Negation that cannot overflow: the most negative code clamps to the most positive.
    function automatic logic [ANC_DATA_W-1:0] sat_neg(input logic [ANC_DATA_W-1:0] x);
        logic [ANC_DATA_W-1:0] most_neg;
        most_neg = {1'b1, {(ANC_DATA_W-1){1'b0}}};
        if (x == most_neg) begin
            return ~most_neg;
        end
        return -x;
    endfunction

endpackage

// File: rtl/anc_frame_sequencer_if.sv
// Sample, filter/update handshake, PWM and status signals of the frame sequencer.
interface anc_frame_sequencer_if
    import anc_pkg::*;
#(
    parameter int DATA_W = ANC_DATA_W
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              adapt_en;
    logic              filt_start;
    logic [DATA_W-1:0] filt_x;
    logic              filt_done;
    logic [DATA_W-1:0] filt_y;
    logic              upd_start;
    logic              upd_done;
    logic [DATA_W-1:0] audio_sample;
    logic              audio_valid;
    logic              busy;
    logic              overrun;
    logic              timeout;
    logic              clear_status;
    logic              spi_led;
    logic [15:0]       frame_count;

    modport master (
        input  rx_valid, rx_data, adapt_en, filt_done, filt_y, upd_done, clear_status,
        output filt_start, filt_x, upd_start, audio_sample, audio_valid,
               busy, overrun, timeout, spi_led, frame_count
    );

    modport slave (
        output rx_valid, rx_data, adapt_en, filt_done, filt_y, upd_done, clear_status,
        input  filt_start, filt_x, upd_start, audio_sample, audio_valid,
               busy, overrun, timeout, spi_led, frame_count
    );

endinterface

// File: rtl/anc_watchdog_timer.sv
// Wait-cycle counter shared by the filter and update handshakes.
module anc_watchdog_timer
    import anc_pkg::*;
#(
    parameter int TIMEOUT_CYC = ANC_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Asserted during the last permitted wait cycle.
    always_comb begin
        expire = enable && (count == CNT_W'(TIMEOUT_CYC - 1));
    end

endmodule

// File: rtl/anc_frame_sequencer.sv
// Per-sample scheduler: FIR filter, optional LMS update, then saturated inverted output to PWM.
module anc_frame_sequencer
    import anc_pkg::*;
#(
    parameter int DATA_W      = ANC_DATA_W,
    parameter int TIMEOUT_CYC = ANC_TIMEOUT_CYC
) (
    input  logic                    Clk_100M,
    input  logic                    ResetSwitch,
    anc_frame_sequencer_if.master   bus
);

    anc_state_t        state;
    anc_state_t        state_d;
    logic              adapt_q;
    logic [DATA_W-1:0] filt_y_q;
    logic              frame_go;
    logic              accept_filt;
    logic              enter_upd;
    logic              enter_out;
    logic              abort;
    logic              overrun_set;
    logic              wd_clear;
    logic              wd_enable;
    logic              wd_expire;

    anc_watchdog_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (Clk_100M),
        .rst    (ResetSwitch),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge Clk_100M) begin
        if (ResetSwitch) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // A done in the expiring cycle takes priority over the abort.
    always_comb begin
        state_d     = state;
        frame_go    = 1'b0;
        accept_filt = 1'b0;
        enter_upd   = 1'b0;
        enter_out   = 1'b0;
        abort       = 1'b0;
        wd_clear    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    state_d  = FILT;
                    frame_go = 1'b1;
                    wd_clear = 1'b1;
                end
            end
            FILT: begin
                if (bus.filt_done) begin
                    accept_filt = 1'b1;
                    if (adapt_q) begin
                        state_d   = UPD;
                        enter_upd = 1'b1;
                        wd_clear  = 1'b1;
                    end else begin
                        state_d   = OUT;
                        enter_out = 1'b1;
                    end
                end else if (wd_expire) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            UPD: begin
                if (bus.upd_done) begin
                    state_d   = OUT;
                    enter_out = 1'b1;
                end else if (wd_expire) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        wd_enable   = (state == FILT) || (state == UPD);
        overrun_set = bus.rx_valid && (state != IDLE);
        bus.busy    = (state != IDLE);
    end

    always_ff @(posedge Clk_100M) begin
        if (ResetSwitch) begin
            adapt_q          <= 1'b0;
            filt_y_q         <= '0;
            bus.filt_start   <= 1'b0;
            bus.filt_x       <= '0;
            bus.upd_start    <= 1'b0;
            bus.audio_sample <= '0;
            bus.audio_valid  <= 1'b0;
            bus.overrun      <= 1'b0;
            bus.timeout      <= 1'b0;
            bus.spi_led      <= 1'b0;
            bus.frame_count  <= '0;
        end else begin
            bus.filt_start  <= frame_go;
            bus.upd_start   <= enter_upd;
            bus.audio_valid <= enter_out;

            if (frame_go) begin
                bus.filt_x <= bus.rx_data;
                adapt_q    <= bus.adapt_en;
            end

            if (accept_filt) begin
                filt_y_q <= bus.filt_y;
            end

            // The no-adapt path commits straight from the live filter output.
            if (enter_out) begin
                bus.audio_sample <= sat_neg(accept_filt ? bus.filt_y : filt_y_q);
                bus.spi_led      <= ~bus.spi_led;
                bus.frame_count  <= bus.frame_count + 16'd1;
            end

            if (overrun_set) begin
                bus.overrun <= 1'b1;
            end else if (bus.clear_status) begin
                bus.overrun <= 1'b0;
            end

            if (abort) begin
                bus.timeout <= 1'b1;
            end else if (bus.clear_status) begin
                bus.timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_anc_frame_sequencer.sv
// Directed vector table plus hand-written timeout, reset and stress sequences for anc_frame_sequencer.
module tb_anc_frame_sequencer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    anc_frame_sequencer_if #(.DATA_W(16)) bus ();

    anc_frame_sequencer #(
        .DATA_W      (16),
        .TIMEOUT_CYC (16)
    ) dut (
        .Clk_100M    (clk),
        .ResetSwitch (rst),
        .bus         (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [15:0] rd;
        logic        ae;
        logic        fd;
        logic [15:0] fy;
        logic        ud;
        logic        cs;
        logic        fs;
        logic        us;
        logic        av;
        logic        by;
        logic        ov;
        logic        to;
        logic        led;
        logic [15:0] as;
        logic [15:0] fx;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs [18];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.rx_valid     = 1'b0;
        bus.rx_data      = 16'h0000;
        bus.adapt_en     = 1'b0;
        bus.filt_done    = 1'b0;
        bus.filt_y       = 16'h0000;
        bus.upd_done     = 1'b0;
        bus.clear_status = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {9'd0, bus.filt_start, bus.upd_start, bus.audio_valid, bus.busy, bus.overrun,
                bus.timeout, bus.spi_led, bus.audio_sample, bus.filt_x, bus.frame_count};
    endfunction

    function automatic logic [63:0] expv(input logic fs, input logic us, input logic av,
                                         input logic by, input logic ov, input logic to,
                                         input logic led, input logic [15:0] as,
                                         input logic [15:0] fx, input logic [15:0] fc);
        return {9'd0, fs, us, av, by, ov, to, led, as, fx, fc};
    endfunction

    function automatic logic [15:0] exp_neg(input logic [15:0] y);
        int v;
        v = -int'($signed(y));
        if (v > 32767) v = 32767;
        return v[15:0];
    endfunction

    task automatic do_frame(input logic [15:0] d, input logic ae, input int unsigned fdly,
                            input int unsigned udly, input logic [15:0] y, input int unsigned idx);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        bus.adapt_en = ae;
        step();
        bus.rx_valid = 1'b0;
        for (int unsigned k = 0; k < fdly; k++) step();
        bus.filt_done = 1'b1;
        bus.filt_y    = y;
        step();
        bus.filt_done = 1'b0;
        if (ae) begin
            for (int unsigned k = 0; k < udly; k++) step();
            bus.upd_done = 1'b1;
            step();
            bus.upd_done = 1'b0;
        end
        check($sformatf("stress%0d_commit", idx), 64'({bus.audio_valid, bus.audio_sample}),
              64'({1'b1, exp_neg(y)}));
        step();
        check($sformatf("stress%0d_idle", idx), 64'({bus.audio_valid, bus.busy}), 64'(2'b00));
        step();
        step();
    endtask

    initial begin
        logic av_seen;
        n_tests = 0;
        n_fail  = 0;

        // rv rd ae fd fy ud cs | fs us av by ov to led as fx fc
        vecs[0]  = '{1'b1, 16'h01F4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h01F4, 16'd0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h01F4, 16'd0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFEDD, 16'h01F4, 16'd1};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFEDD, 16'h01F4, 16'd1};
        vecs[4]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFEDD, 16'h1234, 16'd1};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFEDD, 16'h1234, 16'd1};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFEDD, 16'h1234, 16'd1};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFEDD, 16'h1234, 16'd1};
        vecs[8]  = '{1'b1, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFEDD, 16'h1234, 16'd1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFEDD, 16'h1234, 16'd1};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFEDD, 16'h1234, 16'd1};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h1234, 16'd2};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h1234, 16'd2};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h1234, 16'd2};
        vecs[14] = '{1'b1, 16'h0777, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0777, 16'd2};
        vecs[15] = '{1'b1, 16'h0999, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h0777, 16'd2};
        vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0777, 16'd3};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0777, 16'd3};

        clr_in();
        rst = 1'b1;
        step();
        step();
        check("reset_state", outs(), 64'd0);
        rst = 1'b0;

        for (int unsigned i = 0; i < 18; i++) begin
            bus.rx_valid     = vecs[i].rv;
            bus.rx_data      = vecs[i].rd;
            bus.adapt_en     = vecs[i].ae;
            bus.filt_done    = vecs[i].fd;
            bus.filt_y       = vecs[i].fy;
            bus.upd_done     = vecs[i].ud;
            bus.clear_status = vecs[i].cs;
            step();
            check($sformatf("vec%0d", i), outs(),
                  expv(vecs[i].fs, vecs[i].us, vecs[i].av, vecs[i].by, vecs[i].ov,
                       vecs[i].to, vecs[i].led, vecs[i].as, vecs[i].fx, vecs[i].fc));
        end
        clr_in();

        // filt_done withheld: abort after the 16th FILT cycle
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h0AAA;
        step();
        bus.rx_valid = 1'b0;
        av_seen = 1'b0;
        for (int unsigned k = 0; k < 15; k++) begin
            step();
            if (bus.audio_valid) av_seen = 1'b1;
        end
        check("filt_wait_busy", 64'({bus.busy, bus.timeout}), 64'(2'b10));
        step();
        if (bus.audio_valid) av_seen = 1'b1;
        check("filt_timeout", 64'({bus.busy, bus.timeout, av_seen, bus.audio_sample, bus.frame_count}),
              64'({1'b0, 1'b1, 1'b0, 16'hFFFF, 16'd3}));
        bus.clear_status = 1'b1;
        step();
        bus.clear_status = 1'b0;
        check("timeout_clear", 64'(bus.timeout), 64'(1'b0));

        // filt_done in the 16th FILT cycle wins over the timeout
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h0BBB;
        step();
        bus.rx_valid = 1'b0;
        for (int unsigned k = 0; k < 15; k++) step();
        bus.filt_done = 1'b1;
        bus.filt_y    = 16'h0100;
        step();
        bus.filt_done = 1'b0;
        check("filt_last_cycle", 64'({bus.audio_valid, bus.timeout, bus.spi_led, bus.audio_sample, bus.frame_count}),
              64'({1'b1, 1'b0, 1'b0, 16'hFF00, 16'd4}));
        step();

        // upd_done withheld: abort after the 16th UPD cycle
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h0CCC;
        bus.adapt_en = 1'b1;
        step();
        bus.rx_valid  = 1'b0;
        bus.adapt_en  = 1'b0;
        bus.filt_done = 1'b1;
        bus.filt_y    = 16'h0200;
        step();
        bus.filt_done = 1'b0;
        av_seen = 1'b0;
        for (int unsigned k = 0; k < 15; k++) begin
            step();
            if (bus.audio_valid) av_seen = 1'b1;
        end
        check("upd_wait_busy", 64'({bus.busy, bus.timeout}), 64'(2'b10));
        step();
        if (bus.audio_valid) av_seen = 1'b1;
        check("upd_timeout", 64'({bus.busy, bus.timeout, av_seen, bus.audio_sample, bus.frame_count}),
              64'({1'b0, 1'b1, 1'b0, 16'hFF00, 16'd4}));
        bus.clear_status = 1'b1;
        step();
        bus.clear_status = 1'b0;

        // reset while in UPD, late upd_done ignored
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h0CCC;
        bus.adapt_en = 1'b1;
        step();
        bus.rx_valid  = 1'b0;
        bus.adapt_en  = 1'b0;
        bus.filt_done = 1'b1;
        bus.filt_y    = 16'h0300;
        step();
        bus.filt_done = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.upd_done = 1'b1;
        step();
        bus.upd_done = 1'b0;
        check("reset_mid_frame", outs(), 64'd0);
        step();
        check("after_reset_quiet", outs(), 64'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h0DDD;
        step();
        bus.rx_valid  = 1'b0;
        bus.filt_done = 1'b1;
        bus.filt_y    = 16'h7FFF;
        step();
        bus.filt_done = 1'b0;
        check("post_reset_frame", outs(),
              expv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8001, 16'h0DDD, 16'd1));
        step();

        // stress: 100 back-to-back frames with random handshake delays
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int unsigned f = 0; f < 100; f++) begin
            do_frame(16'($urandom), 1'($urandom_range(1, 0)), $urandom_range(14, 0),
                     $urandom_range(14, 0), 16'($urandom), f);
        end
        check("stress_totals", 64'({bus.frame_count, bus.spi_led, bus.overrun, bus.timeout}),
              64'({16'd100, 3'b000}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/anc_frame_sequencer.md
Name: anc_frame_sequencer

Overview:
Per-sample scheduler for the ANC datapath. It takes each 16-bit ADC word delivered by the SPI receiver and sequences two stages over start/done handshakes: first the FIR anti-noise filter, then, optionally, the LMS weight update. It then commits the saturated, inverted filter output to the audio PWM stage. It sits between the SPI slave and the filter/PWM blocks inside the ANC top level, and also drives the SPI activity LED and sticky error flags.

Parameters:
DATA_W, 16, width of ADC sample, filter output and audio sample
TIMEOUT_CYC, 4000, maximum cycles to wait for any done before aborting the frame (40 us at 100 MHz)

Ports:
Clk_100M  in  1  system clock, 100 MHz
ResetSwitch  in  1  synchronous active-high reset
rx_valid  in  1  one-cycle pulse: new ADC word on rx_data
rx_data  in  DATA_W  ADC sample, two's complement
adapt_en  in  1  enables the LMS update stage; sampled when a frame is accepted
filt_start  out  1  one-cycle pulse: filter may begin on filt_x
filt_x  out  DATA_W  sample held for the filter/update for the whole frame
filt_done  in  1  filter-complete pulse, qualifies filt_y
filt_y  in  DATA_W  filter output
upd_start  out  1  one-cycle pulse: LMS update may begin
upd_done  in  1  update-complete pulse
audio_sample  out  DATA_W  anti-noise sample to PWM, held between commits
audio_valid  out  1  one-cycle pulse on each commit
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: an rx_valid arrived while not IDLE
timeout  out  1  sticky: a handshake exceeded TIMEOUT_CYC
clear_status  in  1  clears overrun and timeout
spi_led  out  1  toggles on every committed frame
frame_count  out  16  committed-frame counter, wraps at 65535 to 0

Behaviour:
- Reset values:
  - state IDLE
  - all outputs 0
  - filt_x = 0, audio_sample = 0
  - timeout counter = 0
- States: IDLE, FILT, UPD, OUT.
- IDLE:
  - rx_valid at edge k latches rx_data into filt_x and latches adapt_en.
  - State becomes FILT at k+1, with filt_start = 1 for that one cycle only.
- FILT:
  - filt_done is accepted in any FILT cycle, including the filt_start cycle. On acceptance filt_y is captured.
  - Next state: UPD if the latched adapt_en = 1 (upd_start pulses on the entry cycle); otherwise OUT.
- UPD: waits for upd_done (accepted from the entry cycle onward), then goes to OUT.
- OUT (one cycle):
  - On entry to OUT, audio_sample = sat_neg(filt_y); audio_valid = 1 during the OUT cycle.
  - In that same cycle spi_led toggles and frame_count increments.
  - Next state is IDLE.
- sat_neg: two's-complement negate, except -32768 maps to +32767.
- Minimum latency with adapt_en = 0 and filt_done in the filt_start cycle: rx_valid at cycle 0, audio_valid at cycle 2.
- Timeout:
  - The counter clears on entry to FILT and on entry to UPD, and increments each wait cycle.
  - If no done has arrived by the cycle where count = TIMEOUT_CYC-1, timeout is set and state goes to IDLE.
  - On abort, audio_sample and frame_count are unchanged and no audio_valid is issued.
  - A done in that final cycle wins over the timeout.
- Overrun:
  - rx_valid in FILT, UPD or OUT sets overrun.
  - The sample is dropped; filt_x is unchanged.
- Sticky flags: clear_status clears overrun and timeout. When a set event and clear_status occur in the same cycle, set wins.
- Stray handshakes: filt_done outside FILT, upd_done outside UPD, and a second done within a stage are all ignored.
- ResetSwitch asserted mid-frame:
  - Next edge goes to IDLE with reset values; no start or valid pulses follow.
  - A done arriving after reset is ignored.

Decomposition:
- Shared package anc_pkg holds:
  - DATA_W constant
  - state encoding (IDLE/FILT/UPD/OUT)
  - sat_neg function
  - TIMEOUT_CYC default
- One natural sub-module: anc_watchdog_timer. It has clear, enable and expire, and is parameterised by TIMEOUT_CYC. It is instantiated once and shared by the FILT and UPD waits.

Test Plan:
- Basic frame: rx_data = 0x01F4, adapt_en = 0, filt_done one cycle after filt_start with filt_y = 0x0123 -> audio_sample = 0xFEDD, one audio_valid, frame_count = 1, spi_led = 1.
- Adapt path: adapt_en = 1, filt_y = 0x8000, upd_done 5 cycles after upd_start -> upd_start is exactly one pulse; audio_sample = 0x7FFF; audio_valid follows upd_done by 1 cycle.
- Overrun: second rx_valid while in UPD -> overrun = 1, filt_x keeps the first sample, one commit only. clear_status -> overrun = 0. Clear coinciding with a new overrun -> overrun stays 1.
- Timeout: filt_done withheld with TIMEOUT_CYC = 16 -> timeout = 1 after 16 FILT cycles, state IDLE, audio_sample unchanged, no audio_valid. Separately, filt_done on cycle 16 -> normal commit, timeout stays 0.
- Reset mid-frame: ResetSwitch in UPD, then upd_done after reset -> all outputs 0, no audio_valid. The next rx_valid runs a normal frame.
- Stress: 100 frames at 20 us spacing with random done delays under 2000 cycles -> frame_count = 100, spi_led = 0, no flags set.
